rle_decoder: RTL and testbench
==============================

# rle_decoder

Hardware run-length decoder: the inverse of the FPGA RLE encoder that the HPS currently feeds through the `fifo_in`/`fifo_out` PIOs. It accepts 24-bit run words in the encoder's output format, `{bit value, 23-bit run length}`, and rebuilds the original byte stream, MSB first. It sits between an input run FIFO (loaded by the HPS or by a DMA) and an output byte FIFO, and closes the compress/decompress loop in fabric.

## Interface
- `RUN_W`, default 24: run word width.
- `LEN_W`, default 23: run-length field width, `run_data[LEN_W-1:0]`. The bit value is `run_data[RUN_W-1]`.
- `BYTE_W`, default 8: output symbol width.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high.
- `run_data`  in  RUN_W  run word.
- `run_valid`  in  1  run word present.
- `run_ready`  out  1  decoder accepts a run this cycle.
- `flush`  in  1  one-cycle pulse: emit the trailing partial byte.
- `byte_data`  out  BYTE_W  decoded byte.
- `byte_valid`  out  1  `byte_data` valid.
- `byte_ready`  in  1  downstream accepts a byte.
- `busy`  out  1  high while a run, partial byte, output byte or flush is pending.
- `err_zero_len`  out  1  one-cycle pulse when a run of length 0 is accepted.

## Operation
- State registers:
  - `val`: bit value of the current run.
  - `rem`: bits remaining in the current run, width LEN_W.
  - `acc`: BYTE_W-bit packing register.
  - `fill`: bits held in `acc`, range 0..8.
  - `flush_pend`.
  - Output register pair `byte_data`/`byte_valid`.
- `run_ready = !reset && rem==0 && !flush_pend`.
- Run accepted (`run_valid && run_ready`):
  - Load `val` and `rem`.
  - If the length is 0: `rem` stays 0, `err_zero_len` pulses on the next cycle, no bits are produced.
- Each cycle:
  - `free = (fill==8 && xfer) ? 8 : 8-fill`, where `xfer = fill==8 && (!byte_valid || byte_ready)`.
  - `n = min(rem, free)`.
  - `acc <= (base << n) | (val ? ((1<<n)-1) : 0)`, where `base` is 0 when `xfer` and `acc` otherwise.
  - `fill <= (xfer ? 0 : fill) + n`; `rem <= rem - n`.
- On `xfer`: `byte_data <= acc`, `byte_valid <= 1`.
- If `byte_valid && byte_ready && !xfer`: `byte_valid <= 0`.
- The first decoded bit lands in `byte_data[7]`.
- Flush:
  - A `flush` pulse sets `flush_pend`.
  - When `rem==0`, `fill` is 1..7 and the output register is free: `byte_data <= acc << (8-fill)` (zero-padded LSBs), `fill <= 0`, clear `flush_pend`.
  - When `rem==0` and `fill==0`: clear `flush_pend`, no byte.
  - When `rem==0` and `fill==8`: normal `xfer` first, then clear.
- `busy = rem!=0 || fill!=0 || byte_valid || flush_pend`.
- Simultaneous events:
  - `flush` in the same cycle as a run acceptance: the run is accepted first, and the flush applies after that run is exhausted.
  - `flush` while `flush_pend` is already set is absorbed.
- Reset, including mid-run: all registers clear. Reset values: `byte_data=0`, `byte_valid=0`, `err_zero_len=0`, `busy=0`, `run_ready=0` during the reset cycle and 1 after it. No stale bits survive.

## Timing
- Run accepted at edge of cycle t:
  - Expansion happens in cycle t+1.
  - First full byte transfers in t+2.
  - `byte_valid` is high in cycle t+3.
- Steady-state throughput: one byte per cycle while `byte_ready` is held high.
- Consecutive runs: one idle cycle between a run exhausting and `run_ready` rising.
- `byte_data` is held stable while `byte_valid && !byte_ready`. Expansion stalls only when `fill==8` and the output register is blocked.
- Length range is 1..2^23-1. `rem` never underflows because `n <= rem`.

## Structure
- Package `rle_pkg`:
  - `RUN_W`, `LEN_W`, `BYTE_W`.
  - `VAL_BIT = RUN_W-1`.
  - `run_t` struct `{logic val; logic [LEN_W-1:0] len;}`. Shared with the encoder.
- Sub-module `rle_bit_packer`: takes `acc`/`fill`/`val`/`n`/`xfer` and returns the new `acc` and `fill`, including the ones-mask merge and the flush left-align.
- The top level holds run load, `rem`, the output register, flush control and the handshakes.

## Test plan
- Run `{1,8}`, `byte_ready=1`: exactly one byte 0xFF, `byte_valid` high 3 cycles after acceptance, then `busy=0`.
- Runs `{1,3}`, `{0,2}`, `{1,3}`: one byte 0xE7; `run_ready` low for the cycle after each run completes.
- Run `{1,5}` then `flush`: one byte 0xF8, `flush_pend` cleared, `busy=0`. A second `flush` with `fill=0` produces no byte.
- Run `{1,24}`, `byte_ready` low for 10 cycles: `byte_valid` stays high, `byte_data` stays 0xFF stable, `run_ready` stays low. After release, three 0xFF bytes arrive on consecutive cycles.
- Run `{0,0}`: `err_zero_len` pulses once, no byte, `run_ready` stays 1. A following `{0,8}` yields 0x00.
- Run `{0,1000}`, `reset` asserted after 3 bytes: next cycle `byte_valid=0`, `busy=0`. A subsequent `{1,8}` yields 0xFF with no leftover zeros.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared run-word layout and widths for the RLE encoder/decoder pair.
package rle_pkg;
  localparam int RUN_W   = 24;
  localparam int LEN_W   = 23;
  localparam int BYTE_W  = 8;
  localparam int VAL_BIT = RUN_W - 1;

  typedef struct packed {
    logic             val;
    logic [LEN_W-1:0] len;
  } run_t;

  // Width of a counter that must hold 0..w inclusive.
  function automatic int fill_bits(int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/rle_bit_packer.sv
// Next-state for the byte packing register: shifts in n copies of the run bit, restarts on xfer.
// Combinational, no backpressure of its own; flush left-aligns the partial byte and empties acc.
module rle_bit_packer
  import rle_pkg::*;
#(
  parameter int BYTE_W = rle_pkg::BYTE_W,
  parameter int FW     = fill_bits(BYTE_W)
) (
  input  logic [BYTE_W-1:0] acc,
  input  logic [FW-1:0]     fill,
  input  logic              val,
  input  logic [FW-1:0]     n,
  input  logic              xfer,
  input  logic              flush,
  output logic [BYTE_W-1:0] acc_nxt,
  output logic [FW-1:0]     fill_nxt,
  output logic [BYTE_W-1:0] flush_byte
);
  logic [BYTE_W-1:0] base;
  logic [BYTE_W-1:0] mask;

  assign base       = xfer ? '0 : acc;
  // n may equal BYTE_W, so build the ones mask by inverting a shifted all-ones word.
  assign mask       = ~({BYTE_W{1'b1}} << n);
  assign flush_byte = acc << (FW'(BYTE_W) - fill);

  always_comb begin
    acc_nxt  = (base << n) | (val ? mask : '0);
    fill_nxt = (xfer ? '0 : fill) + n;
    if (flush) begin
      acc_nxt  = '0;
      fill_nxt = '0;
    end
  end
endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: {bit, length} run words in, MSB-first bytes out; first byte valid 3 cycles after accept.
// Takes a new run only once the current one is expanded; expansion stalls when a full byte meets a blocked output.
module rle_decoder #(
  parameter int RUN_W  = 24,
  parameter int LEN_W  = 23,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RUN_W-1:0]  run_data,
  input  logic              run_valid,
  output logic              run_ready,
  input  logic              flush,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              err_zero_len
);
  import rle_pkg::*;
  localparam int FW = fill_bits(BYTE_W);

  logic              val;
  logic [LEN_W-1:0]  rem;
  logic [BYTE_W-1:0] acc, acc_nxt, flush_byte;
  logic [FW-1:0]     fill, fill_nxt, free, n;
  logic              flush_pend, full, out_free, xfer, accept, do_flush, flush_done;

  assign full     = fill == FW'(BYTE_W);
  assign out_free = !byte_valid || byte_ready;
  assign xfer     = full && out_free;
  assign free     = xfer ? FW'(BYTE_W) : FW'(BYTE_W) - fill;
  assign n        = (rem < LEN_W'(free)) ? FW'(rem) : free;

  assign run_ready = !reset && rem == '0 && !flush_pend;
  assign accept    = run_valid && run_ready;

  // A full byte always leaves through the normal xfer path before the flush retires.
  assign do_flush   = flush_pend && rem == '0 && fill != '0 && !full && out_free;
  assign flush_done = flush_pend && rem == '0 && (fill == '0 || do_flush);

  assign busy = rem != '0 || fill != '0 || byte_valid || flush_pend;

  rle_bit_packer #(.BYTE_W(BYTE_W), .FW(FW)) u_packer (
    .acc        (acc),
    .fill       (fill),
    .val        (val),
    .n          (n),
    .xfer       (xfer),
    .flush      (do_flush),
    .acc_nxt    (acc_nxt),
    .fill_nxt   (fill_nxt),
    .flush_byte (flush_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      val          <= 1'b0;
      rem          <= '0;
      acc          <= '0;
      fill         <= '0;
      flush_pend   <= 1'b0;
      byte_data    <= '0;
      byte_valid   <= 1'b0;
      err_zero_len <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      fill <= fill_nxt;
      if (accept) begin
        val <= run_data[RUN_W-1];
        rem <= run_data[LEN_W-1:0];
      end else begin
        rem <= rem - LEN_W'(n);
      end
      err_zero_len <= accept && run_data[LEN_W-1:0] == '0;

      if (xfer) begin
        byte_data  <= acc;
        byte_valid <= 1'b1;
      end else if (do_flush) begin
        byte_data  <= flush_byte;
        byte_valid <= 1'b1;
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      // A flush arriving while one is still pending is absorbed.
      if (flush_done) flush_pend <= 1'b0;
      else if (flush) flush_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rle_decoder.sv
// Directed timing checks plus randomized runs scored against a bit-queue model of the byte stream.
module tb_rle_decoder;
  import rle_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] run_data = '0;
  logic        run_valid = 1'b0;
  logic        run_ready;
  logic        flush = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        busy;
  logic        err_zero_len;

  rle_decoder dut (
    .clk(clk), .reset(reset), .run_data(run_data), .run_valid(run_valid),
    .run_ready(run_ready), .flush(flush), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
    .err_zero_len(err_zero_len)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   got_cnt = 0;
  int   err_cnt = 0;
  bit   mon_chk = 1'b1;
  bit   rnd_rdy = 1'b0;
  logic [7:0] expq[$];
  bit         bitq[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the decoded stream is just the concatenation of run bits, cut into bytes.
  task automatic model_run(bit v, int len);
    logic [7:0] b;
    for (int i = 0; i < len; i++) bitq.push_back(v);
    while (bitq.size() >= 8) begin
      b = '0;
      for (int k = 0; k < 8; k++) b = {b[6:0], bitq.pop_front()};
      expq.push_back(b);
    end
  endtask

  task automatic model_flush();
    logic [7:0] b;
    int sz;
    sz = bitq.size();
    if (sz > 0) begin
      b = '0;
      for (int k = 0; k < 8; k++) b = {b[6:0], (k < sz) ? bitq.pop_front() : 1'b0};
      expq.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (err_zero_len) err_cnt++;
    if (byte_valid && byte_ready) begin
      got_cnt++;
      if (mon_chk) begin
        check("byte_expected", expq.size() > 0, 1);
        if (expq.size() > 0) check("byte_data", byte_data, expq.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) byte_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_run(bit v, int len, bit fl);
    run_t r;
    r.val = v;
    r.len = len[22:0];
    run_data  = r;
    run_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (run_ready) break;
    end
    check("run_accept", run_ready, 1);
    flush = fl;
    tick();
    run_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle", busy, 0);
    tick();
  endtask

  initial begin
    int base, errs0, zeros;
    bit v;
    int len, nr;

    // reset state
    tick();
    check("rst_run_ready", run_ready, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_zero_len, 0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_run_ready", run_ready, 1);

    // {1,8}: 0xFF, valid three cycles after acceptance
    base = got_cnt;
    model_run(1, 8);
    send_run(1, 8, 0);
    check("t1_bv_c1", byte_valid, 0);
    tick();
    check("t1_bv_c2", byte_valid, 0);
    tick();
    check("t1_bv_c3", byte_valid, 1);
    check("t1_data", byte_data, 8'hFF);
    tick();
    check("t1_busy", busy, 0);
    check("t1_count", got_cnt - base, 1);

    // {1,3},{0,2},{1,3}: 0xE7
    base = got_cnt;
    model_run(1, 3); model_run(0, 2); model_run(1, 3);
    send_run(1, 3, 0);
    check("t2_ready_gap1", run_ready, 0);
    send_run(0, 2, 0);
    check("t2_ready_gap2", run_ready, 0);
    send_run(1, 3, 0);
    check("t2_ready_gap3", run_ready, 0);
    wait_idle(50);
    check("t2_count", got_cnt - base, 1);

    // {1,5} + flush: 0xF8; second flush with nothing held gives no byte
    base = got_cnt;
    model_run(1, 5);
    model_flush();
    send_run(1, 5, 0);
    pulse_flush();
    wait_idle(50);
    check("t3_count", got_cnt - base, 1);
    check("t3_ready", run_ready, 1);
    pulse_flush();
    repeat (4) tick();
    check("t3_noextra", got_cnt - base, 1);
    check("t3_busy", busy, 0);

    // {1,24} with output blocked, then released
    base = got_cnt;
    byte_ready = 1'b0;
    model_run(1, 24);
    send_run(1, 24, 0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_bv", byte_valid, 1);
      check("t4_hold_data", byte_data, 8'hFF);
      check("t4_hold_ready", run_ready, 0);
      tick();
    end
    byte_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_burst_bv", byte_valid, 1);
      check("t4_burst_data", byte_data, 8'hFF);
      tick();
    end
    check("t4_burst_end", byte_valid, 0);
    check("t4_count", got_cnt - base, 3);

    // zero-length run then {0,8}
    base = got_cnt;
    send_run(0, 0, 0);
    check("t5_err", err_zero_len, 1);
    check("t5_ready", run_ready, 1);
    tick();
    check("t5_err_clear", err_zero_len, 0);
    check("t5_nobyte", got_cnt - base, 0);
    model_run(0, 8);
    send_run(0, 8, 0);
    wait_idle(50);
    check("t5_count", got_cnt - base, 1);

    // reset in the middle of a long run
    mon_chk = 1'b0;
    base = got_cnt;
    send_run(0, 1000, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (got_cnt - base >= 3) break;
    end
    check("t6_three_bytes", got_cnt - base >= 3, 1);
    reset = 1'b1;
    #1;
    check("t6_ready_in_rst", run_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    check("t6_bv", byte_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", run_ready, 1);
    expq.delete();
    bitq.delete();
    mon_chk = 1'b1;
    base = got_cnt;
    model_run(1, 8);
    send_run(1, 8, 0);
    wait_idle(50);
    check("t6_after_count", got_cnt - base, 1);
    check("t6_after_empty", expq.size(), 0);

    // randomized segments of runs with random output stalls and flushes
    rnd_rdy = 1'b1;
    errs0 = err_cnt;
    zeros = 0;
    for (int s = 0; s < 40; s++) begin
      nr = $urandom_range(1, 4);
      for (int r = 0; r < nr; r++) begin
        v   = 1'($urandom_range(0, 1));
        len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
        if (len == 0) zeros++;
        model_run(v, len);
        if (r == nr - 1 && $urandom_range(0, 3) == 0) begin
          model_flush();
          send_run(v, len, 1);
        end else begin
          send_run(v, len, 0);
          if (r == nr - 1 && $urandom_range(0, 2) == 0) begin
            model_flush();
            pulse_flush();
          end
        end
      end
    end
    model_flush();
    pulse_flush();
    wait_idle(5000);
    rnd_rdy = 1'b0;
    byte_ready = 1'b1;
    check("rnd_leftover", expq.size(), 0);
    check("rnd_err_pulses", err_cnt - errs0, zeros);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
